pcm_capture_ctrl: RTL and testbench
===================================

# pcm_capture_ctrl

Capture sequencer between the decimated PCM stream (`pcm_out`/`pcm_ready` of the I2S top) and the byte-wide sample FIFO read out by the host. It starts and stops recordings on command and discards microphone warm-up samples. It splits each signed sample into bytes, MSB first, under FIFO back-pressure, and counts both captured and dropped samples.

## Interface
- `DATA_SIZE`, 24: PCM sample width; multiple of 8.
- `BYTES`, DATA_SIZE/8: bytes per sample (derived, not overridden).
- `COUNT_WIDTH`, 24: width of sample target and counters.
- `WARMUP_SAMPLES`, 256: samples discarded after start; 0 disables warm-up.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: one-cycle pulse, begins a capture.
- `stop` in 1: one-cycle pulse, ends a capture.
- `sample_target` in COUNT_WIDTH: samples per capture; 0 = continuous until `stop`; sampled on accepted `start`.
- `trig_level` in DATA_SIZE-1: magnitude threshold (used only with the trigger macro).
- `pcm_in` in DATA_SIZE: signed PCM sample.
- `pcm_valid` in 1: one-cycle strobe, `pcm_in` valid.
- `fifo_full` in 1: FIFO cannot accept a byte this cycle.
- `fifo_wr_en` out 1: byte write strobe.
- `fifo_wr_data` out 8: byte to write.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle pulse at end of capture.
- `overflow` out 1: sticky; a sample was dropped during the current capture.
- `sample_count` out COUNT_WIDTH: samples fully written in the current/last capture.
- `drop_count` out COUNT_WIDTH: samples dropped, saturating.

## Operation
- States: IDLE, WARMUP, ARMED (only with macro), CAPTURE, DRAIN.
- IDLE: `start` && !`stop` → latch `sample_target`; clear `sample_count`, `drop_count`, `overflow` → WARMUP, or next state directly if `WARMUP_SAMPLES`=0. If `start` and `stop` coincide, `stop` wins and the block stays IDLE.
- `start` outside IDLE is ignored.
- WARMUP: count `pcm_valid` strobes and discard them. After the `WARMUP_SAMPLES`-th strobe → ARMED (macro) or CAPTURE.
- CAPTURE, `pcm_valid` with serializer empty: latch `pcm_in`, byte index = BYTES-1.
- CAPTURE, `pcm_valid` with serializer holding a sample: drop the new sample, set `overflow`, increment `drop_count` (saturate at all-ones).
- Serializer: `fifo_wr_en` = loaded && !`fifo_full` (combinational); `fifo_wr_data` = latched[8·idx+7:8·idx].
- Each write decrements idx. The write at idx 0 empties the serializer and increments `sample_count`.
- If `sample_target`≠0 and `sample_count` reaches the target → IDLE with `done`.
- `stop` in WARMUP/ARMED → IDLE with `done`.
- `stop` in CAPTURE: if serializer empty → IDLE with `done`; otherwise → DRAIN.
- DRAIN: ignore `pcm_valid` (no drop counted) and finish the current sample, then → IDLE with `done`.
- Target and `stop` reached in the same cycle: a single `done` pulse.
- Counters hold their values in IDLE until the next accepted `start`.

## Timing
- Reset values: `fifo_wr_en`=0, `fifo_wr_data`=0, `busy`=0, `done`=0, `overflow`=0, `sample_count`=0, `drop_count`=0. State = IDLE, serializer empty.
- Reset mid-capture aborts immediately; a partial sample is lost and no `done` is issued.
- `pcm_valid` at cycle N (CAPTURE, serializer empty) → first byte eligible at N+1. With no back-pressure, bytes are written at N+1…N+BYTES.
- `fifo_full` stalls in place; no byte is skipped or repeated.
- The write at idx 0 occurs at cycle M. `sample_count` updates at M+1. When the target is reached, `done`=1 and `busy`=0 at M+1.
- `stop` at cycle S with serializer empty → `done`=1, `busy`=0 at S+1.
- A `pcm_valid` arriving in the same cycle as the final byte write of the previous sample counts as a drop; the serializer is not double-loaded.

## Configuration
- `PCM_CAPTURE_TRIGGER_EN` defined: after warm-up, stay in ARMED.
  - In ARMED, each `pcm_valid` computes |`pcm_in`|. The most-negative value saturates to 2^(DATA_SIZE-1)-1.
  - |`pcm_in`| ≥ `trig_level` → that same sample is latched as the first captured sample, → CAPTURE.
  - Samples below threshold are discarded and not counted as drops.
- Undefined: no ARMED state; `trig_level` is unused; WARMUP goes directly to CAPTURE.

## Test plan
- Basic: WARMUP_SAMPLES=2, target=3, samples 0x123456, 0xABCDEF, 0x000001 after 2 warm-ups → bytes 12 34 56 AB CD EF 00 00 01; `done` once; `sample_count`=3; `overflow`=0.
- Back-pressure: `fifo_full` high for 5 cycles mid-sample 0x123456 → bytes 12 34 56 with no repeat or skip; write count exactly 3.
- Overflow: hold `fifo_full` while 3 `pcm_valid` strobes arrive → 1 sample captured, `drop_count`=2, `overflow`=1.
- Stop/drain: target=0; `stop` after the first byte of 0x0A0B0C → 0A 0B 0C written, then `done`. A `pcm_valid` during DRAIN is not written and not counted.
- `start` and `stop` in the same cycle → stays IDLE, `busy`=0. Reset asserted mid-sample → all outputs at reset values next cycle.
- Trigger (macro): `trig_level`=0x100; samples 0x000050, 0xFFFE00 → first captured byte FF (|−512| ≥ 256); the sample 0x000050 is discarded.

Source files
------------

// File: rtl/pcm_capture_ctrl.sv
// PCM capture sequencer: warm-up discard, optional magnitude trigger (PCM_CAPTURE_TRIGGER_EN), MSB-first byte split.
// Latency: pcm_valid at N -> first byte at N+1; done registered one cycle after the final byte or stop.
// Backpressure: fifo_full stalls the serializer in place; samples arriving while it is loaded are dropped and counted.
module pcm_capture_ctrl #(
  parameter int DATA_SIZE      = 24,
  parameter int COUNT_WIDTH    = 24,
  parameter int WARMUP_SAMPLES = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic [COUNT_WIDTH-1:0] sample_target,
  input  logic [DATA_SIZE-2:0]   trig_level,
  input  logic [DATA_SIZE-1:0]   pcm_in,
  input  logic                   pcm_valid,
  input  logic                   fifo_full,
  output logic                   fifo_wr_en,
  output logic [7:0]             fifo_wr_data,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic [COUNT_WIDTH-1:0] sample_count,
  output logic [COUNT_WIDTH-1:0] drop_count
);

  localparam int BYTES = DATA_SIZE / 8;
  localparam int IW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int WW    = (WARMUP_SAMPLES > 1) ? $clog2(WARMUP_SAMPLES) : 1;
  localparam logic [WW-1:0] WARM_LAST = WW'((WARMUP_SAMPLES > 0) ? WARMUP_SAMPLES - 1 : 0);
  localparam logic [IW-1:0] IDX_TOP   = IW'(BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    WARMUP,
`ifdef PCM_CAPTURE_TRIGGER_EN
    ARMED,
`endif
    CAPTURE,
    DRAIN
  } state_t;

`ifdef PCM_CAPTURE_TRIGGER_EN
  localparam state_t POST_WARM = ARMED;
`else
  localparam state_t POST_WARM = CAPTURE;
`endif

  state_t                  state, next_state;
  logic [COUNT_WIDTH-1:0]  target_q;
  logic [WW-1:0]           warm_cnt;
  logic [BYTES-1:0][7:0]   shreg;
  logic [IW-1:0]           idx;
  logic                    loaded;

  logic start_acc;
  logic load;
  logic drop;
  logic warm_inc;
  logic last_wr;
  logic target_hit;

  assign fifo_wr_en   = loaded && !fifo_full;
  assign fifo_wr_data = loaded ? shreg[idx] : 8'h00;
  assign busy         = (state != IDLE);
  assign last_wr      = fifo_wr_en && (idx == '0);
  assign target_hit   = last_wr && (target_q != '0) &&
                        ((sample_count + COUNT_WIDTH'(1)) == target_q);

`ifdef PCM_CAPTURE_TRIGGER_EN
  logic [DATA_SIZE-1:0] pcm_neg;
  logic [DATA_SIZE-2:0] pcm_mag;
  logic                 trig_hit;

  assign pcm_neg = ~pcm_in + DATA_SIZE'(1);

  // The most-negative code has no positive twin; clamp it to full scale.
  always_comb begin
    pcm_mag = pcm_in[DATA_SIZE-2:0];
    if (pcm_in[DATA_SIZE-1]) begin
      if (pcm_in[DATA_SIZE-2:0] == '0) pcm_mag = '1;
      else                             pcm_mag = pcm_neg[DATA_SIZE-2:0];
    end
  end

  assign trig_hit = (pcm_mag >= trig_level);
`else
  logic unused_trig;
  assign unused_trig = ^trig_level;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    start_acc  = 1'b0;
    load       = 1'b0;
    drop       = 1'b0;
    warm_inc   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !stop) begin
          start_acc  = 1'b1;
          next_state = (WARMUP_SAMPLES == 0) ? POST_WARM : WARMUP;
        end
      end
      WARMUP: begin
        if (stop) begin
          next_state = IDLE;
        end else if (pcm_valid) begin
          warm_inc = 1'b1;
          if (warm_cnt == WARM_LAST) next_state = POST_WARM;
        end
      end
`ifdef PCM_CAPTURE_TRIGGER_EN
      ARMED: begin
        if (stop) begin
          next_state = IDLE;
        end else if (pcm_valid && trig_hit) begin
          load       = 1'b1;
          next_state = CAPTURE;
        end
      end
`endif
      CAPTURE: begin
        // A strobe during the final byte still sees the serializer busy and is dropped.
        if (pcm_valid && loaded)             drop = 1'b1;
        else if (pcm_valid && !stop)         load = 1'b1;
        if (target_hit)                      next_state = IDLE;
        else if (stop && (!loaded || last_wr)) next_state = IDLE;
        else if (stop)                       next_state = DRAIN;
      end
      DRAIN: begin
        if (last_wr || !loaded) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_q     <= '0;
      warm_cnt     <= '0;
      shreg        <= '0;
      idx          <= '0;
      loaded       <= 1'b0;
      sample_count <= '0;
      drop_count   <= '0;
      overflow     <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= (state != IDLE) && (next_state == IDLE);
      if (start_acc) begin
        target_q     <= sample_target;
        warm_cnt     <= '0;
        sample_count <= '0;
        drop_count   <= '0;
        overflow     <= 1'b0;
      end
      if (warm_inc) warm_cnt <= warm_cnt + WW'(1);
      if (fifo_wr_en) begin
        if (idx == '0) begin
          loaded       <= 1'b0;
          sample_count <= sample_count + COUNT_WIDTH'(1);
        end else begin
          idx <= idx - IW'(1);
        end
      end
      if (load) begin
        shreg  <= pcm_in;
        idx    <= IDX_TOP;
        loaded <= 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + COUNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_pcm_capture_ctrl.sv
// Self-checking bench for pcm_capture_ctrl: scoreboard of expected FIFO bytes plus per-scenario checks.
module tb_pcm_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop;
  logic [23:0] sample_target;
  logic [22:0] trig_level;
  logic [23:0] pcm_in;
  logic        pcm_valid;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [7:0]  fifo_wr_data;
  logic        busy, done, overflow;
  logic [23:0] sample_count, drop_count;

  int pass_cnt = 0;
  int total    = 0;
  int done_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  pcm_capture_ctrl #(.DATA_SIZE(24), .COUNT_WIDTH(24), .WARMUP_SAMPLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .sample_target(sample_target), .trig_level(trig_level),
    .pcm_in(pcm_in), .pcm_valid(pcm_valid), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .busy(busy), .done(done), .overflow(overflow),
    .sample_count(sample_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (fifo_wr_en) got_q.push_back(fifo_wr_data);
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [23:0] v);
    pcm_in    = v;
    pcm_valid = 1'b1;
    tick();
    pcm_valid = 1'b0;
  endtask

  task automatic expect_sample(input logic [23:0] v);
    exp_q.push_back(v[23:16]);
    exp_q.push_back(v[15:8]);
    exp_q.push_back(v[7:0]);
  endtask

  task automatic begin_capture(input logic [23:0] tgt);
    sample_target = tgt;
    start = 1'b1;
    tick();
    start = 1'b0;
    send(24'h111111);
    send(24'h222222);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 50 && busy; i++) tick();
    total++;
    if (busy !== 1'b0) $display("FAIL %s_timeout busy=%0b expected 0", name, busy);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; stop = 0; sample_target = 0; trig_level = 23'h100;
    pcm_in = 0; pcm_valid = 0; fifo_full = 0;
    tick(); tick();
    total++; if (fifo_wr_en !== 1'b0) $display("FAIL reset_wr_en got=%0b exp=0", fifo_wr_en); else pass_cnt++;
    total++; if (fifo_wr_data !== 8'h00) $display("FAIL reset_wr_data got=%0h exp=0", fifo_wr_data); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", busy); else pass_cnt++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got=%0b exp=0", done); else pass_cnt++;
    total++; if (overflow !== 1'b0) $display("FAIL reset_overflow got=%0b exp=0", overflow); else pass_cnt++;
    total++; if (sample_count !== 24'd0) $display("FAIL reset_sample_count got=%0h exp=0", sample_count); else pass_cnt++;
    total++; if (drop_count !== 24'd0) $display("FAIL reset_drop_count got=%0h exp=0", drop_count); else pass_cnt++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int d0;
    logic [7:0] e, g;
    d0 = done_cnt;
    begin_capture(24'd3);
    expect_sample(24'h123456);
    send(24'h123456);
    total++;
    if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 8'h12)
      $display("FAIL basic_latency got en=%0b data=%0h exp en=1 data=12", fifo_wr_en, fifo_wr_data);
    else pass_cnt++;
    tick(); tick(); tick();
    expect_sample(24'hABCDEF);
    send(24'hABCDEF);
    tick(); tick(); tick();
    expect_sample(24'h000001);
    send(24'h000001);
    tick(); tick(); tick();
    total++; if (done !== 1'b1) $display("FAIL basic_done_timing got=%0b exp=1", done); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL basic_busy_timing got=%0b exp=0", busy); else pass_cnt++;
    total++; if (sample_count !== 24'd3) $display("FAIL basic_sample_count got=%0d exp=3", sample_count); else pass_cnt++;
    total++; if (overflow !== 1'b0) $display("FAIL basic_overflow got=%0b exp=0", overflow); else pass_cnt++;
    tick(); tick();
    total++; if (done_cnt - d0 !== 1) $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt - d0); else pass_cnt++;
    total++; if (got_q.size() !== exp_q.size()) $display("FAIL basic_byte_count got=%0d exp=%0d", got_q.size(), exp_q.size()); else pass_cnt++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      total++; if (g !== e) $display("FAIL basic_byte got=%0h exp=%0h", g, e); else pass_cnt++;
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_backpressure();
    logic [7:0] e, g;
    begin_capture(24'd1);
    expect_sample(24'h123456);
    send(24'h123456);
    tick();
    fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (fifo_wr_en !== 1'b0) $display("FAIL bp_stall_wr_en got=%0b exp=0", fifo_wr_en); else pass_cnt++;
    end
    fifo_full = 1'b0;
    wait_idle("bp");
    total++; if (sample_count !== 24'd1) $display("FAIL bp_sample_count got=%0d exp=1", sample_count); else pass_cnt++;
    total++; if (got_q.size() !== 3) $display("FAIL bp_write_count got=%0d exp=3", got_q.size()); else pass_cnt++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      total++; if (g !== e) $display("FAIL bp_byte got=%0h exp=%0h", g, e); else pass_cnt++;
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_overflow();
    logic [7:0] e, g;
    begin_capture(24'd0);
    fifo_full = 1'b1;
    expect_sample(24'h0F1E2D);
    send(24'h0F1E2D);
    send(24'h333333);
    send(24'h444444);
    total++; if (drop_count !== 24'd2) $display("FAIL ovf_drop_count got=%0d exp=2", drop_count); else pass_cnt++;
    total++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got=%0b exp=1", overflow); else pass_cnt++;
    fifo_full = 1'b0;
    tick(); tick(); tick(); tick();
    stop = 1'b1; tick(); stop = 1'b0;
    total++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL ovf_stop got done=%0b busy=%0b exp done=1 busy=0", done, busy); else pass_cnt++;
    total++; if (sample_count !== 24'd1) $display("FAIL ovf_sample_count got=%0d exp=1", sample_count); else pass_cnt++;
    total++; if (got_q.size() !== 3) $display("FAIL ovf_write_count got=%0d exp=3", got_q.size()); else pass_cnt++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      total++; if (g !== e) $display("FAIL ovf_byte got=%0h exp=%0h", g, e); else pass_cnt++;
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_stop_drain();
    logic [7:0] e, g;
    begin_capture(24'd0);
    expect_sample(24'h0A0B0C);
    send(24'h0A0B0C);
    tick();
    stop = 1'b1; tick(); stop = 1'b0;
    total++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL drain_state got busy=%0b done=%0b exp busy=1 done=0", busy, done); else pass_cnt++;
    send(24'h777777);
    total++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL drain_done got done=%0b busy=%0b exp done=1 busy=0", done, busy); else pass_cnt++;
    total++; if (drop_count !== 24'd0) $display("FAIL drain_drop_count got=%0d exp=0", drop_count); else pass_cnt++;
    total++; if (sample_count !== 24'd1) $display("FAIL drain_sample_count got=%0d exp=1", sample_count); else pass_cnt++;
    tick(); tick(); tick(); tick();
    total++; if (got_q.size() !== 3) $display("FAIL drain_write_count got=%0d exp=3", got_q.size()); else pass_cnt++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      total++; if (g !== e) $display("FAIL drain_byte got=%0h exp=%0h", g, e); else pass_cnt++;
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_start_stop_same();
    sample_target = 24'd5;
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL startstop_busy got=%0b exp=0", busy); else pass_cnt++;
    tick();
    total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL startstop_idle got busy=%0b done=%0b exp 0 0", busy, done); else pass_cnt++;
    total++; if (sample_count !== 24'd1) $display("FAIL startstop_counts_held got=%0d exp=1", sample_count); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    begin_capture(24'd0);
    fifo_full = 1'b1;
    send(24'h555555);
    send(24'h666666);
    rst_n = 1'b0;
    fifo_full = 1'b0;
    tick();
    total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL rstmid_busy_done got busy=%0b done=%0b exp 0 0", busy, done); else pass_cnt++;
    total++; if (fifo_wr_en !== 1'b0 || fifo_wr_data !== 8'h00) $display("FAIL rstmid_fifo got en=%0b data=%0h exp 0 0", fifo_wr_en, fifo_wr_data); else pass_cnt++;
    total++; if (overflow !== 1'b0 || drop_count !== 24'd0 || sample_count !== 24'd0)
      $display("FAIL rstmid_counters got ovf=%0b drops=%0d samples=%0d exp 0 0 0", overflow, drop_count, sample_count);
    else pass_cnt++;
    rst_n = 1'b1;
    tick(); tick();
    total++; if (got_q.size() !== 0) $display("FAIL rstmid_no_writes got=%0d exp=0", got_q.size()); else pass_cnt++;
    exp_q.delete(); got_q.delete();
  endtask

`ifdef PCM_CAPTURE_TRIGGER_EN
  task automatic test_trigger();
    logic [7:0] e, g;
    trig_level = 23'h100;
    begin_capture(24'd1);
    send(24'h000050);
    expect_sample(24'hFFFE00);
    send(24'hFFFE00);
    wait_idle("trig");
    total++; if (drop_count !== 24'd0) $display("FAIL trig_drop_count got=%0d exp=0", drop_count); else pass_cnt++;
    total++; if (sample_count !== 24'd1) $display("FAIL trig_sample_count got=%0d exp=1", sample_count); else pass_cnt++;
    total++; if (got_q.size() !== 3) $display("FAIL trig_write_count got=%0d exp=3", got_q.size()); else pass_cnt++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      total++; if (g !== e) $display("FAIL trig_byte got=%0h exp=%0h", g, e); else pass_cnt++;
    end
    exp_q.delete(); got_q.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_stop_drain();
    test_start_stop_same();
    test_reset_mid();
`ifdef PCM_CAPTURE_TRIGGER_EN
    test_trigger();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
